// File: rtl/text_write_ctrl_if.sv
// rtl/text_write_ctrl_if.sv - byte-in / RAM-write-out bundle for the text write controller
//
// Purpose : groups the UART byte handshake, the character RAM write port and
//           the cursor/status outputs of text_write_ctrl.
// Signals : data_in[7:0], data_ready      - received byte and its one-cycle strobe
//           wr_en, wr_addr, wr_data[7:0]  - character RAM write port
//           cursor_col, cursor_row        - logical cursor position
//           top_row                       - physical RAM row shown at screen top
//           busy, overflow                - status
// Modports: master - byte source / RAM+status sink (testbench, UART side)
//           slave  - the controller itself
interface text_write_ctrl_if #(
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5,
    parameter int ADDR_W = 12
);
    logic [7:0]        data_in;
    logic              data_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [COL_W-1:0]  cursor_col;
    logic [ROW_W-1:0]  cursor_row;
    logic [ROW_W-1:0]  top_row;
    logic              busy;
    logic              overflow;

    modport master (
        output data_in, data_ready,
        input  wr_en, wr_addr, wr_data, cursor_col, cursor_row, top_row, busy, overflow
    );

    modport slave (
        input  data_in, data_ready,
        output wr_en, wr_addr, wr_data, cursor_col, cursor_row, top_row, busy, overflow
    );
endinterface

// File: rtl/text_write_ctrl.sv
// rtl/text_write_ctrl.sv - cursor-tracking write controller for the VGA character buffer
//
// Purpose : takes decoded UART bytes, interprets printable characters and
//           CR/LF/BS/FF, and sequences cell writes, line clears, full-screen
//           clears and scrolling into the character RAM.
// Ports   : clk   - system clock
//           reset - synchronous, active-low reset
//           bus   - text_write_ctrl_if.slave (byte input, RAM write port,
//                   cursor_col/cursor_row/top_row, busy, overflow)
// Config  : TEXT_SCROLL_EN - when defined, a line advance on the last row
//           scrolls by moving top_row; otherwise the cursor wraps to row 0.
module text_write_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5,
    parameter int ADDR_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    text_write_ctrl_if.slave bus
);
    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]    ROWS_X      = (ROW_W + 1)'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(ROWS * COLS - 1);
    localparam logic [7:0]        SPACE       = 8'h20;

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR_LINE, CLEAR_ALL} state_t;

    state_t            state;
    logic [7:0]        pend;
    logic              pend_valid;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  top;
    logic [ADDR_W-1:0] cnt;
    logic              clr_after;   // a printable wrap on the last row owes a line clear
    logic [ADDR_W-1:0] clr_base;

    logic [ROW_W:0]    row_sum;
    logic [ROW_W-1:0]  phys_row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] bs_addr;
    logic [COL_W-1:0]  col_dec;
    logic [ROW_W-1:0]  la_row;
    logic [ROW_W-1:0]  la_top;
    logic              la_clear;
    logic [ADDR_W-1:0] la_base;
    logic              consume;
    logic              printable;

    assign bus.cursor_col = col;
    assign bus.cursor_row = row;
    assign bus.top_row    = top;
    assign bus.busy       = (state != IDLE) || pend_valid;

    always_comb begin
        // Both operands are below ROWS, so one conditional subtract is a full modulo.
        row_sum   = {1'b0, top} + {1'b0, row};
        phys_row  = (row_sum >= ROWS_X) ? ROW_W'(row_sum - ROWS_X) : row_sum[ROW_W-1:0];
        row_base  = ADDR_W'(phys_row) * COLS_A;
        cur_addr  = row_base + ADDR_W'(col);
        col_dec   = col - 1'b1;
        bs_addr   = row_base + ADDR_W'(col_dec);
        consume   = (state == IDLE) && pend_valid;
        printable = (pend >= 8'h20) && (pend <= 8'h7E);

        // Outcome of a line advance from the current cursor position.
        la_row   = row;
        la_top   = top;
        la_clear = 1'b0;
        la_base  = '0;
        if (row < LAST_ROW) begin
            la_row = row + 1'b1;
        end else begin
            la_clear = 1'b1;
`ifdef TEXT_SCROLL_EN
            // The old top row becomes the new bottom row after the scroll.
            la_top  = (top == LAST_ROW) ? '0 : top + 1'b1;
            la_base = ADDR_W'(top) * COLS_A;
`else
            la_row  = '0;
            la_top  = '0;
            la_base = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            pend         <= '0;
            pend_valid   <= 1'b0;
            col          <= '0;
            row          <= '0;
            top          <= '0;
            cnt          <= '0;
            clr_after    <= 1'b0;
            clr_base     <= '0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.overflow <= 1'b0;
        end else begin
            // One-deep holding register; a slot freed this cycle may be refilled.
            bus.overflow <= 1'b0;
            if (bus.data_ready) begin
                if (!pend_valid || consume) begin
                    pend       <= bus.data_in;
                    pend_valid <= 1'b1;
                end else begin
                    bus.overflow <= 1'b1;
                end
            end else if (consume) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        if (printable) begin
                            state       <= WRITE;
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= cur_addr;
                            bus.wr_data <= pend;
                            if (col == LAST_COL) begin
                                col       <= '0;
                                row       <= la_row;
                                top       <= la_top;
                                clr_after <= la_clear;
                                clr_base  <= la_base;
                            end else begin
                                col       <= col + 1'b1;
                                clr_after <= 1'b0;
                            end
                        end else begin
                            case (pend)
                                8'h0D: col <= '0;
                                8'h0A: begin
                                    row <= la_row;
                                    top <= la_top;
                                    if (la_clear) begin
                                        state       <= CLEAR_LINE;
                                        bus.wr_en   <= 1'b1;
                                        bus.wr_addr <= la_base;
                                        bus.wr_data <= SPACE;
                                        cnt         <= '0;
                                    end
                                end
                                8'h08: begin
                                    if (col != '0) begin
                                        state       <= WRITE;
                                        col         <= col_dec;
                                        clr_after   <= 1'b0;
                                        bus.wr_en   <= 1'b1;
                                        bus.wr_addr <= bs_addr;
                                        bus.wr_data <= SPACE;
                                    end
                                end
                                8'h0C: begin
                                    state       <= CLEAR_ALL;
                                    bus.wr_en   <= 1'b1;
                                    bus.wr_addr <= '0;
                                    bus.wr_data <= SPACE;
                                    cnt         <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                WRITE: begin
                    if (clr_after) begin
                        // Chain straight into the line clear without a gap cycle.
                        state       <= CLEAR_LINE;
                        clr_after   <= 1'b0;
                        bus.wr_addr <= clr_base;
                        bus.wr_data <= SPACE;
                        cnt         <= '0;
                    end else begin
                        state     <= IDLE;
                        bus.wr_en <= 1'b0;
                    end
                end

                CLEAR_LINE: begin
                    if (cnt == LINE_LAST) begin
                        state     <= IDLE;
                        bus.wr_en <= 1'b0;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        bus.wr_addr <= bus.wr_addr + 1'b1;
                    end
                end

                CLEAR_ALL: begin
                    if (cnt == SCREEN_LAST) begin
                        state     <= IDLE;
                        bus.wr_en <= 1'b0;
                        col       <= '0;
                        row       <= '0;
                        top       <= '0;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        bus.wr_addr <= bus.wr_addr + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    bus.wr_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_text_write_ctrl.sv
// tb/tb_text_write_ctrl.sv - directed self-checking bench for text_write_ctrl
module tb_text_write_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    text_write_ctrl_if bus ();

    text_write_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ovf_cnt = 0;
    logic [19:0] wlog[$];

    // Record every RAM write (addr, data) and every overflow pulse.
    always @(negedge clk) begin
        if (bus.wr_en) wlog.push_back({bus.wr_addr, bus.wr_data});
        if (bus.overflow) ovf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.data_in    = b;
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        while (bus.busy && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bus.busy, 0);
    endtask

    task automatic send_wait(input logic [7:0] b);
        send(b);
        wait_idle("idle_timeout", 3000);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wlog.delete();
        ovf_cnt = 0;
    endtask

    initial begin
        int bad;
        bus.data_in    = 8'h00;
        bus.data_ready = 1'b0;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_col", bus.cursor_col, 0);
        chk("rst_row", bus.cursor_row, 0);
        chk("rst_top", bus.top_row, 0);
        chk("rst_ovf", bus.overflow, 0);
        reset = 1'b1;
        wlog.delete();

        // Single write latency
        send(8'h41);
        chk("a_pend_busy", bus.busy, 1);
        chk("a_no_wr_yet", bus.wr_en, 0);
        @(negedge clk);
        chk("a_wr_en", bus.wr_en, 1);
        chk("a_wr_addr", bus.wr_addr, 0);
        chk("a_wr_data", bus.wr_data, 8'h41);
        chk("a_col", bus.cursor_col, 1);
        chk("a_row", bus.cursor_row, 0);
        @(negedge clk);
        chk("a_wr_done", bus.wr_en, 0);
        chk("a_busy_low", bus.busy, 0);

        // Control codes
        do_reset();
        send_wait(8'h41);
        send_wait(8'h42);
        send_wait(8'h0D);
        send_wait(8'h0A);
        send_wait(8'h43);
        chk("cc_nwr", wlog.size(), 3);
        chk("cc_w0", wlog[0], {12'd0, 8'h41});
        chk("cc_w1", wlog[1], {12'd1, 8'h42});
        chk("cc_w2", wlog[2], {12'd80, 8'h43});
        chk("cc_col", bus.cursor_col, 1);
        chk("cc_row", bus.cursor_row, 1);
        wlog.delete();
        send_wait(8'h08);
        chk("bs_nwr", wlog.size(), 1);
        chk("bs_w0", wlog[0], {12'd80, 8'h20});
        chk("bs_col", bus.cursor_col, 0);
        chk("bs_row", bus.cursor_row, 1);
        wlog.delete();
        send_wait(8'h08);
        chk("bs0_nwr", wlog.size(), 0);
        chk("bs0_col", bus.cursor_col, 0);

        // Column wrap with back-to-back bytes every 2 cycles
        do_reset();
        for (int i = 0; i < 80; i++) begin
            send(8'(8'h41 + i % 26));
            @(negedge clk);
        end
        wait_idle("wrap_timeout", 100);
        chk("wrap_nwr", wlog.size(), 80);
        bad = 0;
        for (int i = 0; i < 80; i++)
            if (wlog[i] !== {12'(i), 8'(8'h41 + i % 26)}) bad++;
        chk("wrap_seq_bad", bad, 0);
        chk("wrap_ovf", ovf_cnt, 0);
        chk("wrap_col", bus.cursor_col, 0);
        chk("wrap_row", bus.cursor_row, 1);

        // Clear-all
        wlog.delete();
        send_wait(8'h0C);
        chk("ff_nwr", wlog.size(), 2400);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== {12'(i), 8'h20}) bad++;
        chk("ff_seq_bad", bad, 0);
        chk("ff_col", bus.cursor_col, 0);
        chk("ff_row", bus.cursor_row, 0);
        chk("ff_top", bus.top_row, 0);

        // Line advance at the last row
        do_reset();
        for (int i = 0; i < 29; i++) send_wait(8'h0A);
        chk("lf29_row", bus.cursor_row, 29);
        chk("lf29_nwr", wlog.size(), 0);
        send_wait(8'h0A);
        chk("scr_nwr", wlog.size(), 80);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== {12'(i), 8'h20}) bad++;
        chk("scr_seq_bad", bad, 0);
`ifdef TEXT_SCROLL_EN
        chk("scr_top", bus.top_row, 1);
        chk("scr_row", bus.cursor_row, 29);
`else
        chk("scr_top", bus.top_row, 0);
        chk("scr_row", bus.cursor_row, 0);
`endif
        wlog.delete();
        send_wait(8'h58);
        chk("scr_x_nwr", wlog.size(), 1);
        chk("scr_x_w0", wlog[0], {12'd0, 8'h58});

        // Overflow during a line clear
        do_reset();
        for (int i = 0; i < 29; i++) send_wait(8'h0A);
        wlog.delete();
        ovf_cnt = 0;
        send(8'h0A);
        @(negedge clk);
        chk("ovf_in_clear", bus.wr_en, 1);
        for (int k = 0; k < 3; k++) begin
            bus.data_in    = 8'(8'h50 + k);
            bus.data_ready = 1'b1;
            @(negedge clk);
        end
        bus.data_ready = 1'b0;
        wait_idle("ovf_timeout", 200);
        chk("ovf_cnt", ovf_cnt, 2);
        chk("ovf_nwr", wlog.size(), 81);
        chk("ovf_held", wlog[80], {12'd0, 8'h50});
        chk("ovf_col", bus.cursor_col, 1);

        // Reset in the middle of a clear-all
        do_reset();
        send_wait(8'h41);
        send_wait(8'h42);
        send(8'h0C);
        @(negedge clk);
        repeat (100) @(negedge clk);
        chk("mid_wr_en", bus.wr_en, 1);
        chk("mid_wr_addr", bus.wr_addr, 100);
        chk("mid_col", bus.cursor_col, 2);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_wr_en", bus.wr_en, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_col", bus.cursor_col, 0);
        chk("mid_rst_row", bus.cursor_row, 0);
        chk("mid_rst_top", bus.top_row, 0);
        reset = 1'b1;
        @(negedge clk);
        wlog.delete();
        send_wait(8'h5A);
        chk("post_rst_nwr", wlog.size(), 1);
        chk("post_rst_w0", wlog[0], {12'd0, 8'h5A});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/text_write_ctrl.md
# text_write_ctrl

Write-side controller for the character buffer of the VGA text display. It consumes decoded UART bytes and tracks a cursor. It interprets printable characters and control codes (CR, LF, BS, FF), then sequences single-cell writes, line clears, full-screen clears and hardware scrolling into the character RAM. The block sits between the UART receiver and the text buffer RAM write port; the VGA read side uses `top_row` as the display row offset.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 30, rows per screen
- `COL_W`, 7, cursor column width
- `ROW_W`, 5, cursor/top-row width
- `ADDR_W`, 12, character RAM address width (must cover `ROWS*COLS`)

- `clk` input 1 — system clock
- `reset` input 1 — synchronous, active-low reset
- `data_in` input 8 — received byte
- `data_ready` input 1 — one-cycle strobe, `data_in` valid
- `wr_en` output 1 — RAM write enable, registered
- `wr_addr` output ADDR_W — RAM write address, registered
- `wr_data` output 8 — RAM write data, registered
- `cursor_col` output COL_W — current cursor column
- `cursor_row` output ROW_W — current logical cursor row (0 = top of screen)
- `top_row` output ROW_W — physical RAM row shown at screen top
- `busy` output 1 — state ≠ IDLE or pending byte held
- `overflow` output 1 — one-cycle pulse, byte dropped

## Operation
- **Pending register:** one byte deep.
  - `data_ready` loads it and sets `pend_valid`.
  - If `pend_valid`=1 and the FSM does not consume it that cycle, the new byte is dropped and `overflow` pulses.
  - Consume and new arrival in the same cycle: the new byte is captured and there is no overflow.
- **Physical address:** `((top_row + cursor_row) mod ROWS) * COLS + cursor_col`.
- **States:**
  - IDLE, WRITE, CLEAR_LINE, CLEAR_ALL.
  - All states other than IDLE return to IDLE.
  - In IDLE with `pend_valid`, the FSM consumes the byte and decodes it as follows.
- **Printable bytes (0x20–0x7E):** WRITE.
  - Emit one write (`wr_data`=byte) at the cursor, then advance the column.
  - At `COLS-1` the column wraps to 0 and a line advance is performed.
- **0x0D CR:** column ← 0; no write; stays IDLE.
- **0x0A LF:** line advance; column unchanged.
- **0x08 BS:**
  - If column > 0: column−1, then WRITE 0x20 at the new position.
  - At column 0: no-op.
- **0x0C FF:** enter CLEAR_ALL.
  - Writes 0x20 to addresses 0 … `ROWS*COLS-1`, one per cycle.
  - Then cursor ← (0,0) and `top_row` ← 0.
- **All other bytes:** ignored.
- **Line advance:**
  - If row < `ROWS-1`: row+1, no clear.
  - At `ROWS-1`: scroll (see Configuration) and enter CLEAR_LINE for the new bottom physical row.
- **CLEAR_LINE:** writes 0x20 to `row_base` … `row_base+COLS-1`, one per cycle.
- **Control-only line advance:** LF at the last row enters CLEAR_LINE. Printable-wrap at the last row does WRITE, then CLEAR_LINE.

## Timing
- **Reset values:** all outputs 0; `pend_valid`=0; state IDLE.
  - A reset mid-clear aborts immediately.
  - RAM contents are not cleared by reset.
- **Latency:** `data_ready` sampled at edge N → consumed at edge N+1 → `wr_en`=1 with address/data valid during cycle N+1…N+2.
- **Cursor update:** cursor outputs update on the same edge that asserts `wr_en`.
- **Durations:**
  - Printable/BS: 1 write cycle.
  - CLEAR_LINE: `COLS` cycles.
  - CLEAR_ALL: `ROWS*COLS` cycles.
  - Back-to-back printable bytes every 2 cycles are sustainable without overflow.
- **Address arithmetic:**
  - Modulo `ROWS` is done by compare-and-subtract; no divider.
  - Address counters wrap-checked at `COLS-1` and `ROWS*COLS-1`.
- **Busy:** `busy` deasserts on the cycle after the final clear write.

## Configuration
- `TEXT_SCROLL_EN` defined:
  - Line advance at the last row increments `top_row` mod `ROWS`.
  - `cursor_row` stays `ROWS-1`.
  - The vacated physical row (old `top_row`) is cleared.
- `TEXT_SCROLL_EN` undefined:
  - `top_row` is held at 0.
  - Line advance at the last row sets `cursor_row` to 0 and clears physical row 0.

## Test plan
- **Reset and single write:** reset low 3 cycles, then 'A' (0x41) → `wr_en` one cycle later with `wr_addr`=0, `wr_data`=0x41; cursor (1,0); `busy` low 2 cycles after strobe.
- **Control codes:** "AB", CR, LF, 'C' → writes at 0, 1, then 80; BS → 0x20 written at addr 80, cursor (0,1); BS again → no write.
- **Column wrap and clear-all:**
  - 80 printable bytes on row 0 → cursor (0,1).
  - FF → exactly 2400 writes of 0x20, addresses 0–2399 ascending, then cursor (0,0).
- **Scroll (TEXT_SCROLL_EN):** 29 LFs then LF → `top_row`=1; 80 writes of 0x20 at addresses 0–79; next 'X' written at addr 0.
- **Overflow:** strobes on 3 consecutive cycles during CLEAR_LINE → 1st held, 2nd and 3rd dropped, `overflow` pulses twice; the held byte is processed after the clear.
- **Reset mid-operation:** `reset` low at cycle 100 of CLEAR_ALL → next cycle `wr_en`=0, `busy`=0, cursor (0,0), `top_row`=0.
